ifetch_unit: RTL and testbench

Instruction fetch front end for the MIPS pipeline: owns the fetch PC, issues word reads to instruction memory over a valid/ready request channel, collects responses and buffers {pc, instruction} pairs in a small FIFO for decode. It is the consumer side of the PC path. It reads from its own PC, advances it, and accepts redirects (branch/jump/exception targets) from later stages, flushing wrong-path work.

---
 rtl/ifetch_unit_if.sv | 28 ++
 rtl/ifetch_unit.sv | 161 ++++++++++++++++
 tb/tb_ifetch_unit.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_unit_if.sv
// Signal bundle for ifetch_unit: instruction-memory request/response, redirect input and decode-side FIFO head.
// master is the fetch unit, slave is the memory/pipeline environment around it.
interface ifetch_unit_if #(
  parameter int WIDTH = 32
);
  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [WIDTH-1:0] imem_req_addr;
  logic             imem_rsp_valid;
  logic [WIDTH-1:0] imem_rsp_data;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic             inst_valid;
  logic             inst_ready;
  logic [WIDTH-1:0] inst_data;
  logic [WIDTH-1:0] inst_pc;
  logic             fetch_fault;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, fetch_fault,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, fetch_fault,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: owns the fetch PC, keeps one word read in flight and queues {pc, instruction} for decode.
// Optional IFETCH_ALIGN_CHECK_EN: misaligned redirects raise fetch_fault and park the unit in HALT.
module ifetch_unit #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h8002_0000
) (
  input logic           clock,
  input logic           reset,
  ifetch_unit_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] req_pc_q, req_pc_d;
  logic             fault_q, fault_d;
  logic             halt_pend_q, halt_pend_d;

  logic [CNT_W-1:0] cnt_q;
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [WIDTH-1:0] fifo_pc_q   [DEPTH];
  logic [WIDTH-1:0] fifo_data_q [DEPTH];

  logic             req_valid_s, req_hs_s, inst_valid_s;
  logic             push_s, pop_s, flush_s, outstanding_s;
  logic [WIDTH-1:0] redir_pc_s;

  // Request valid is a function of state and occupancy only, never of redirect.
  assign req_valid_s   = !reset && (state_q == ST_FETCH) && (cnt_q < CNT_W'(DEPTH));
  assign req_hs_s      = req_valid_s && bus.imem_req_ready;
  assign inst_valid_s  = (cnt_q != {CNT_W{1'b0}});
  assign pop_s         = inst_valid_s && bus.inst_ready;
  assign redir_pc_s    = bus.redirect_pc & ALIGN_MASK;
  assign outstanding_s = (((state_q == ST_WAIT) || (state_q == ST_DROP)) && !bus.imem_rsp_valid) || req_hs_s;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic misalign_s;
  assign misalign_s = |bus.redirect_pc[1:0];
`endif

  // Next-state, PC advance and FIFO push/flush decisions
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    fault_d     = fault_q;
    halt_pend_d = halt_pend_q;
    push_s      = 1'b0;
    flush_s     = 1'b0;
    if (bus.redirect_valid) begin
      flush_s = 1'b1;
      pc_d    = redir_pc_s;
`ifdef IFETCH_ALIGN_CHECK_EN
      fault_d     = misalign_s;
      halt_pend_d = misalign_s;
      if (outstanding_s) begin
        state_d = ST_DROP;
      end else if (misalign_s) begin
        state_d = ST_HALT;
      end else begin
        state_d = ST_FETCH;
      end
`else
      if (outstanding_s) begin
        state_d = ST_DROP;
      end else begin
        state_d = ST_FETCH;
      end
`endif
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (req_hs_s) begin
            pc_d     = pc_q + WIDTH'(3'd4);
            req_pc_d = pc_q;
            state_d  = ST_WAIT;
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rsp_valid) begin
            push_s  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_DROP: begin
          if (bus.imem_rsp_valid) begin
            state_d     = halt_pend_q ? ST_HALT : ST_FETCH;
            halt_pend_d = 1'b0;
          end else begin
            state_d = ST_DROP;
          end
        end
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_FETCH;
      endcase
    end
  end

  // Control registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      fault_q     <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      fault_q     <= fault_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  // FIFO pointers and occupancy; a redirect empties it even if a pop coincides
  always_ff @(posedge clock) begin
    if (reset || flush_s) begin
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(push_s) - CNT_W'(pop_s);
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1'b1);
      end
    end
  end

  // FIFO storage
  always_ff @(posedge clock) begin
    if (push_s) begin
      fifo_pc_q[wr_ptr_q]   <= req_pc_q;
      fifo_data_q[wr_ptr_q] <= bus.imem_rsp_data;
    end
  end

  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = inst_valid_s;
  assign bus.inst_data      = inst_valid_s ? fifo_data_q[rd_ptr_q] : '0;
  assign bus.inst_pc        = inst_valid_s ? fifo_pc_q[rd_ptr_q] : '0;
  assign bus.fetch_fault    = fault_q;
endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: expected {pc, data} pairs are queued by the stimulus, a monitor pops them on delivery.
module tb_ifetch_unit;
  logic clock;
  logic reset;

  ifetch_unit_if #(.WIDTH(32)) bus ();

  ifetch_unit #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h8002_0000)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int          n_chk    = 0;
  int          n_fail   = 0;
  int          hs_total = 0;
  int          mem_lat  = 1;
  logic [31:0] exp_q[$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hFFFF_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  // Raise req_ready until k more handshakes have happened, then drop it.
  task automatic issue(input int k, input int exp_cyc);
    int target;
    int cyc;
    target = hs_total + k;
    cyc = 0;
    bus.imem_req_ready = 1'b1;
    while (hs_total < target && cyc < 300) begin
      tick();
      cyc++;
    end
    bus.imem_req_ready = 1'b0;
    chk("issue_handshakes", 32'(hs_total), 32'(target));
    if (exp_cyc != 0) chk("issue_cycles", 32'(cyc), 32'(exp_cyc));
  endtask

  // Raise req_ready and return in the cycle after the next handshake (ready left high).
  task automatic wait_hs();
    int prev;
    int cyc;
    prev = hs_total;
    cyc = 0;
    bus.imem_req_ready = 1'b1;
    while (hs_total == prev && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("wait_hs", 32'(hs_total), 32'(prev + 1));
  endtask

  task automatic redirect(input logic [31:0] a);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = a;
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  // Memory model: one outstanding read, response mem_lat cycles after the handshake.
  initial begin : mem_model
    logic        pend;
    int          cd;
    logic [31:0] paddr;
    pend = 1'b0;
    cd = 0;
    paddr = 32'h0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clock);
      if (bus.imem_req_valid === 1'b1 && bus.imem_req_ready === 1'b1) begin
        pend  = 1'b1;
        cd    = mem_lat;
        paddr = bus.imem_req_addr;
      end
      @(posedge clock);
      #1;
      bus.imem_rsp_valid = 1'b0;
      if (pend) begin
        cd--;
        if (cd == 0) begin
          pend = 1'b0;
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = mem_word(paddr);
        end
      end
    end
  end

  // Monitor: count request handshakes, check every delivered instruction against the scoreboard.
  always @(negedge clock) begin : monitor
    logic [31:0] e;
    if (bus.imem_req_valid === 1'b1 && bus.imem_req_ready === 1'b1) hs_total++;
    if (bus.inst_valid === 1'b1 && bus.inst_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_inst: got pc %h data %h, expected none", bus.inst_pc, bus.inst_data);
      end else begin
        e = exp_q.pop_front();
        chk("inst_pc", bus.inst_pc, e);
        chk("inst_data", bus.inst_data, mem_word(e));
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.inst_ready     = 1'b1;

    // Reset values
    tick();
    @(negedge clock);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst_data", bus.inst_data, 32'h0);
    chk("rst_inst_pc", bus.inst_pc, 32'h0);
    chk("rst_fault", 32'(bus.fetch_fault), 32'd0);
    chk("rst_req_addr", bus.imem_req_addr, 32'h8002_0000);
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("post_rst_req_addr", bus.imem_req_addr, 32'h8002_0000);
    tick();

    // Streaming, 1-cycle memory: one instruction per 2 cycles
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h8002_0000 + 32'(4 * i));
    issue(8, 15);
    settle(4);
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: exactly DEPTH requests, then resume without loss
    bus.inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h8002_0020 + 32'(4 * i));
    begin
      int prev;
      prev = hs_total;
      bus.imem_req_ready = 1'b1;
      settle(20);
      @(negedge clock);
      chk("full_req_valid", 32'(bus.imem_req_valid), 32'd0);
      chk("full_hs_count", 32'(hs_total - prev), 32'd4);
    end
    tick();
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h8002_0030 + 32'(4 * i));
    issue(4, 0);
    settle(4);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Redirect while WAIT, 3-cycle memory, FIFO holding stale entries
    mem_lat = 3;
    bus.inst_ready = 1'b0;
    issue(2, 0);
    settle(4);
    wait_hs();
    bus.imem_req_ready = 1'b0;
    redirect(32'h8003_0000);
    @(negedge clock);
    chk("wait_redir_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("wait_redir_drop_req", 32'(bus.imem_req_valid), 32'd0);
    tick();
    bus.inst_ready = 1'b1;
    exp_q.push_back(32'h8003_0000);
    exp_q.push_back(32'h8003_0004);
    issue(2, 0);
    settle(6);
    chk("wait_redir_drained", 32'(exp_q.size()), 32'd0);

    // Redirect coincident with request handshake -> DROP
    mem_lat = 1;
    bus.imem_req_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8004_0000;
    tick();
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b0;
    @(negedge clock);
    chk("hs_redir_drop_req", 32'(bus.imem_req_valid), 32'd0);
    chk("hs_redir_inst_valid", 32'(bus.inst_valid), 32'd0);
    tick();
    @(negedge clock);
    chk("hs_redir_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("hs_redir_req_addr", bus.imem_req_addr, 32'h8004_0000);
    tick();
    exp_q.push_back(32'h8004_0000);
    exp_q.push_back(32'h8004_0004);
    issue(2, 0);
    settle(4);

    // Redirect coincident with rsp_valid in WAIT -> straight to FETCH
    wait_hs();
    bus.imem_req_ready = 1'b0;
    redirect(32'h8005_0000);
    @(negedge clock);
    chk("rsp_redir_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("rsp_redir_req_addr", bus.imem_req_addr, 32'h8005_0000);
    chk("rsp_redir_inst_valid", 32'(bus.inst_valid), 32'd0);
    tick();
    exp_q.push_back(32'h8005_0000);
    exp_q.push_back(32'h8005_0004);
    issue(2, 0);
    settle(4);

    // PC wrap
    redirect(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    issue(3, 0);
    settle(4);
    chk("wrap_drained", 32'(exp_q.size()), 32'd0);

    // Misaligned redirect
    redirect(32'h8003_0002);
    @(negedge clock);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("misalign_fault", 32'(bus.fetch_fault), 32'd1);
    tick();
    begin
      int prev;
      prev = hs_total;
      bus.imem_req_ready = 1'b1;
      settle(5);
      bus.imem_req_ready = 1'b0;
      chk("halt_no_requests", 32'(hs_total), 32'(prev));
    end
    @(negedge clock);
    chk("halt_req_valid", 32'(bus.imem_req_valid), 32'd0);
    tick();
`else
    chk("misalign_fault", 32'(bus.fetch_fault), 32'd0);
    chk("misalign_req_addr", bus.imem_req_addr, 32'h8003_0000);
    tick();
    exp_q.push_back(32'h8003_0000);
    issue(1, 0);
    settle(4);
`endif
    redirect(32'h8003_0004);
    @(negedge clock);
    chk("aligned_fault", 32'(bus.fetch_fault), 32'd0);
    chk("aligned_req_addr", bus.imem_req_addr, 32'h8003_0004);
    tick();
    exp_q.push_back(32'h8003_0004);
    issue(1, 0);
    settle(4);

    // Reset with a request in flight; the late response must be ignored
    mem_lat = 3;
    wait_hs();
    bus.imem_req_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("midrst_req_addr", bus.imem_req_addr, 32'h8002_0000);
    chk("midrst_inst_valid", 32'(bus.inst_valid), 32'd0);
    settle(2);
    @(negedge clock);
    chk("midrst_stale_ignored", 32'(bus.inst_valid), 32'd0);
    tick();
    exp_q.push_back(32'h8002_0000);
    exp_q.push_back(32'h8002_0004);
    issue(2, 0);
    settle(6);

    chk("final_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
